// File: rtl/dual_port_bram_bytewise.sv
// Common-clock true dual-port RAM with byte write enables and optional post-reset zero-clear.
// Every accepted request returns read-first data after READ_LATENCY cycles; ready_o=0 while resetting or clearing.
module dual_port_bram_bytewise #(
    parameter int DATA_WIDTH     = 64,
    parameter int DATA_DEPTH     = 1024,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 3,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  ena_i,
    input  logic [NUM_BYTES-1:0]  wea_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic [DATA_WIDTH-1:0] dina_i,
    output logic [DATA_WIDTH-1:0] douta_o,
    output logic                  valida_o,
    input  logic                  enb_i,
    input  logic [NUM_BYTES-1:0]  web_i,
    input  logic [ADDR_WIDTH-1:0] addrb_i,
    input  logic [DATA_WIDTH-1:0] dinb_i,
    output logic [DATA_WIDTH-1:0] doutb_o,
    output logic                  validb_o
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [1:0]            acc;
    logic [1:0]            in_rng;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] rd_dat [2];
    logic [DATA_WIDTH-1:0] dout [2];
    logic [1:0]            vld_out;
    logic [NUM_BYTES-1:0]  wea_eff, web_eff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we     = !rst_i;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign ready_o = (state_q == ST_RUN) && !rst_i;

    assign addr[0] = addra_i;
    assign addr[1] = addrb_i;
    assign acc     = {enb_i, ena_i} & {2{ready_o}};

    // On a same-address double write, port A owns every lane it enables.
    assign wea_eff = (acc[0] && in_rng[0]) ? wea_i : '0;
    assign web_eff = ((acc[1] && in_rng[1]) ? web_i : '0)
                   & ~((addra_i == addrb_i) ? wea_eff : '0);

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wea_eff[i]) mem_q[addra_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (web_eff[i]) mem_q[addrb_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [READ_LATENCY-1:0] vld_q;
        logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

        assign in_rng[p] = ({1'b0, addr[p]} < DEPTH_L);
        assign rd_dat[p] = in_rng[p] ? mem_q[addr[p]] : '0;

        // Stages only advance on valid data so the output holds between pulses.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= '0;
                for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
            end else begin
                vld_q[0] <= acc[p];
                if (acc[p]) dat_q[0] <= rd_dat[p];
                for (int k = 1; k < READ_LATENCY; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
                end
            end
        end

        assign vld_out[p] = vld_q[READ_LATENCY-1];
        assign dout[p]    = dat_q[READ_LATENCY-1];
    end

    assign douta_o  = rst_i ? '0 : dout[0];
    assign doutb_o  = rst_i ? '0 : dout[1];
    assign valida_o = vld_out[0] && !rst_i;
    assign validb_o = vld_out[1] && !rst_i;

endmodule

// File: tb/tb_dual_port_bram_bytewise.sv
// Bench for dual_port_bram_bytewise: a 16-deep clearing instance and a 10-deep retaining instance.
module tb_dual_port_bram_bytewise;

    localparam int LAT = 3;

    typedef struct {
        logic        ena;
        logic [7:0]  wea;
        logic [3:0]  addra;
        logic [63:0] dina;
        logic [63:0] expa;
        logic        enb;
        logic [7:0]  web;
        logic [3:0]  addrb;
        logic [63:0] dinb;
        logic [63:0] expb;
        logic        dc;
    } vec_t;

    typedef struct {
        logic [63:0] dat;
        int          cyc;
        logic        dc;
    } exp_t;

    logic        clk;
    int          cyc;
    int          checks;
    int          errors;
    exp_t        q0[$], q1[$], q2[$], q3[$];

    logic        rst16, ready16, ena16, enb16, valida16, validb16;
    logic [7:0]  wea16, web16;
    logic [3:0]  addra16, addrb16;
    logic [63:0] dina16, dinb16, douta16, doutb16;

    logic        rst10, ready10, ena10, enb10, valida10, validb10;
    logic [7:0]  wea10, web10;
    logic [3:0]  addra10, addrb10;
    logic [63:0] dina10, dinb10, douta10, doutb10;

    dual_port_bram_bytewise #(
        .DATA_WIDTH(64), .DATA_DEPTH(16), .BYTE_WIDTH(8), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) u16 (
        .clk_i(clk), .rst_i(rst16), .ready_o(ready16),
        .ena_i(ena16), .wea_i(wea16), .addra_i(addra16), .dina_i(dina16), .douta_o(douta16), .valida_o(valida16),
        .enb_i(enb16), .web_i(web16), .addrb_i(addrb16), .dinb_i(dinb16), .doutb_o(doutb16), .validb_o(validb16)
    );

    dual_port_bram_bytewise #(
        .DATA_WIDTH(64), .DATA_DEPTH(10), .BYTE_WIDTH(8), .READ_LATENCY(LAT), .CLEAR_ON_RESET(0)
    ) u10 (
        .clk_i(clk), .rst_i(rst10), .ready_o(ready10),
        .ena_i(ena10), .wea_i(wea10), .addra_i(addra10), .dina_i(dina10), .douta_o(douta10), .valida_o(valida10),
        .enb_i(enb10), .web_i(web10), .addrb_i(addrb10), .dinb_i(dinb10), .doutb_o(doutb10), .validb_o(validb10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int ch, input logic [63:0] act);
        exp_t e;
        int   n;
        case (ch)
            0:       n = q0.size();
            1:       n = q1.size();
            2:       n = q2.size();
            default: n = q3.size();
        endcase
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid_ch%0d: got valid with data %h at cycle %0d, required no valid", ch, act, cyc);
        end else begin
            case (ch)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                2:       e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            if (!e.dc) chk($sformatf("dout_ch%0d", ch), act, e.dat);
            chk($sformatf("valid_cycle_ch%0d", ch), 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (valida16) pop_cmp(0, douta16);
        if (validb16) pop_cmp(1, doutb16);
        if (valida10) pop_cmp(2, douta10);
        if (validb10) pop_cmp(3, doutb10);
    end

    function automatic vec_t mk(input logic ea, input logic [7:0] wa, input logic [3:0] aa, input logic [63:0] da,
                                input logic [63:0] xa, input logic eb, input logic [7:0] wb, input logic [3:0] ab,
                                input logic [63:0] db, input logic [63:0] xb);
        vec_t v;
        v = '{ea, wa, aa, da, xa, eb, wb, ab, db, xb, 1'b0};
        return v;
    endfunction

    // Apply one vector for one cycle; expectations queued only for requests the DUT must accept.
    task automatic drive(input bit s10, input vec_t v, input bit push);
        if (!s10) begin
            ena16 = v.ena; wea16 = v.wea; addra16 = v.addra; dina16 = v.dina;
            enb16 = v.enb; web16 = v.web; addrb16 = v.addrb; dinb16 = v.dinb;
            if (push && v.ena) q0.push_back('{dat: v.expa, cyc: cyc + LAT, dc: v.dc});
            if (push && v.enb) q1.push_back('{dat: v.expb, cyc: cyc + LAT, dc: 1'b0});
        end else begin
            ena10 = v.ena; wea10 = v.wea; addra10 = v.addra; dina10 = v.dina;
            enb10 = v.enb; web10 = v.web; addrb10 = v.addrb; dinb10 = v.dinb;
            if (push && v.ena) q2.push_back('{dat: v.expa, cyc: cyc + LAT, dc: v.dc});
            if (push && v.enb) q3.push_back('{dat: v.expb, cyc: cyc + LAT, dc: 1'b0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit s10, input int n);
        for (int i = 0; i < n; i++) drive(s10, mk(1'b0, 8'h00, 4'd0, 64'h0, 64'h0, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0), 1'b0);
    endtask

    // Counts negedges with ready16 low after a reset release; bounded.
    task automatic meas16(output int n);
        n = 0;
        @(negedge clk);
        while (!ready16 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    vec_t tbl [16];
    vec_t v;
    int   n;

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = mk(1'b1, 8'hFF, 4'd5,  64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0);
        tbl[1]  = mk(1'b0, 8'h00, 4'd0,  64'h0, 64'h0, 1'b1, 8'h00, 4'd4, 64'h0, 64'h0);
        tbl[2]  = mk(1'b0, 8'h00, 4'd0,  64'h0, 64'h0, 1'b1, 8'h00, 4'd5, 64'h0, 64'hDEAD_BEEF_0123_4567);
        tbl[3]  = mk(1'b0, 8'h00, 4'd0,  64'h0, 64'h0, 1'b1, 8'h00, 4'd6, 64'h0, 64'h0);
        tbl[4]  = mk(1'b1, 8'hFF, 4'd7,  64'h1111_1111_1111_1111, 64'h0, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0);
        tbl[5]  = mk(1'b1, 8'h0F, 4'd7,  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 1'b1, 8'h00, 4'd7, 64'h0, 64'h1111_1111_1111_1111);
        tbl[6]  = mk(1'b1, 8'h00, 4'd7,  64'h0, 64'h1111_1111_2222_2222, 1'b1, 8'h00, 4'd7, 64'h0, 64'h1111_1111_2222_2222);
        tbl[7]  = mk(1'b1, 8'h0F, 4'd3,  64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b1, 8'h3C, 4'd3, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0);
        tbl[8]  = mk(1'b1, 8'h00, 4'd3,  64'h0, 64'h0000_BBBB_AAAA_AAAA, 1'b1, 8'h00, 4'd3, 64'h0, 64'h0000_BBBB_AAAA_AAAA);
        tbl[9]  = mk(1'b1, 8'h00, 4'd9,  64'h0, 64'h0, 1'b1, 8'h81, 4'd9, 64'h0123_4567_89AB_CDEF, 64'h0);
        tbl[10] = mk(1'b1, 8'h00, 4'd9,  64'h0, 64'h0100_0000_0000_00EF, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0);
        tbl[11] = mk(1'b1, 8'hF0, 4'd10, 64'h5555_5555_5555_5555, 64'h0, 1'b1, 8'hFF, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0100_0000_0000_00EF);
        tbl[12] = mk(1'b1, 8'h00, 4'd9,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h00, 4'd10, 64'h0, 64'h5555_5555_0000_0000);
        tbl[13] = mk(1'b1, 8'h00, 4'd9,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h00, 4'd9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        tbl[14] = mk(1'b1, 8'hFF, 4'd15, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b1, 8'h00, 4'd0, 64'h0, 64'h0);
        tbl[15] = mk(1'b1, 8'h00, 4'd15, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 8'h00, 4'd15, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F);

        rst16 = 1'b1;
        rst10 = 1'b1;
        ena16 = 1'b0; wea16 = '0; addra16 = '0; dina16 = '0; enb16 = 1'b0; web16 = '0; addrb16 = '0; dinb16 = '0;
        ena10 = 1'b0; wea10 = '0; addra10 = '0; dina10 = '0; enb10 = 1'b0; web10 = '0; addrb10 = '0; dinb10 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready16", 64'(ready16), 64'h0);
        chk("rst_valida16", 64'(valida16), 64'h0);
        chk("rst_validb16", 64'(validb16), 64'h0);
        chk("rst_douta16", douta16, 64'h0);
        chk("rst_doutb16", doutb16, 64'h0);
        chk("rst_ready10", 64'(ready10), 64'h0);
        chk("rst_douta10", douta10, 64'h0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        rst10 = 1'b0;
        meas16(n);
        chk("clear_ready_low_cycles", 64'(n), 64'd16);
        @(posedge clk);
        #1;

        for (int a = 0; a < 16; a++)
            drive(1'b0, mk(1'b1, 8'h00, 4'(a), 64'h0, 64'h0, 1'b1, 8'h00, 4'(15 - a), 64'h0, 64'h0), 1'b1);

        for (int i = 0; i < 16; i++) drive(1'b0, tbl[i], 1'b1);
        idle(1'b0, 6);
        chk("hold_douta16", douta16, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("hold_doutb16", doutb16, 64'h0F0F_0F0F_0F0F_0F0F);

        // Read in flight when reset hits must never produce a valid pulse.
        drive(1'b0, mk(1'b1, 8'h00, 4'd5, 64'h0, 64'h0, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0), 1'b0);
        ena16 = 1'b0;
        rst16 = 1'b1;
        @(negedge clk);
        chk("midrst_ready16", 64'(ready16), 64'h0);
        chk("midrst_douta16", douta16, 64'h0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        ena16 = 1'b1; wea16 = 8'hFF; addra16 = 4'd5; dina16 = 64'h1234_5678_9ABC_DEF0;
        enb16 = 1'b1; web16 = 8'hFF; addrb16 = 4'd6; dinb16 = 64'h0FED_CBA9_8765_4321;
        meas16(n);
        ena16 = 1'b0;
        enb16 = 1'b0;
        chk("reclear_ready_low_cycles", 64'(n), 64'd16);
        chk("reclear_douta16", douta16, 64'h0);

        @(posedge clk);
        #1;
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        meas16(n);
        chk("restart_ready_low_cycles", 64'(n), 64'd16);
        @(posedge clk);
        #1;
        drive(1'b0, mk(1'b1, 8'h00, 4'd5, 64'h0, 64'h0, 1'b1, 8'h00, 4'd6, 64'h0, 64'h0), 1'b1);
        drive(1'b0, mk(1'b1, 8'h00, 4'd15, 64'h0, 64'h0, 1'b1, 8'h00, 4'd7, 64'h0, 64'h0), 1'b1);
        idle(1'b0, 1);

        // Retaining 10-deep instance: out-of-range handling and memory kept across reset.
        v = mk(1'b1, 8'hFF, 4'd9, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0, 8'h00, 4'd0, 64'h0, 64'h0);
        v.dc = 1'b1;
        drive(1'b1, v, 1'b1);
        drive(1'b1, mk(1'b1, 8'hFF, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 8'hFF, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0), 1'b1);
        drive(1'b1, mk(1'b1, 8'h00, 4'd12, 64'h0, 64'h0, 1'b1, 8'h00, 4'd9, 64'h0, 64'hCAFE_F00D_1234_5678), 1'b1);
        drive(1'b1, mk(1'b1, 8'h00, 4'd10, 64'h0, 64'h0, 1'b1, 8'h00, 4'd11, 64'h0, 64'h0), 1'b1);
        idle(1'b1, 5);
        rst10 = 1'b1;
        ena10 = 1'b1; wea10 = 8'hFF; addra10 = 4'd9; dina10 = 64'h0;
        @(negedge clk);
        chk("rst_ready10_again", 64'(ready10), 64'h0);
        chk("rst_valida10", 64'(valida10), 64'h0);
        @(posedge clk);
        #1;
        rst10 = 1'b0;
        ena10 = 1'b0;
        @(negedge clk);
        chk("noclear_ready10_first_cycle", 64'(ready10), 64'h1);
        @(posedge clk);
        #1;
        drive(1'b1, mk(1'b1, 8'h00, 4'd9, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b1, 8'h00, 4'd12, 64'h0, 64'h0), 1'b1);
        idle(1'b1, 6);

        chk("drained_q0", 64'(q0.size()), 64'h0);
        chk("drained_q1", 64'(q1.size()), 64'h0);
        chk("drained_q2", 64'(q2.size()), 64'h0);
        chk("drained_q3", 64'(q3.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
